// File: rtl/layer00_out_writer_pkg.sv
// layer00_out_writer_pkg: shared pixel/word geometry and writer FSM states
package layer00_out_writer_pkg;
  localparam int PIX_W  = 8;
  localparam int PACK_N = 4;
  localparam int WORD_W = PIX_W * PACK_N;
  localparam int LANE_W = $clog2(PACK_N);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/layer00_out_writer_if.sv
// layer00_out_writer_if: pooled-pixel input and BRAM write/status bundle
interface layer00_out_writer_if import layer00_out_writer_pkg::*; #(
  parameter int ADDR_W = 12
) ();
  logic              i_start;
  logic              i_vld;
  logic [PIX_W-1:0]  i_data;
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [WORD_W-1:0] o_wdata;
  logic              o_busy;
  logic              o_done;
  modport master (output i_start, i_vld, i_data, input o_we, o_addr, o_wdata, o_busy, o_done);
  modport slave  (input i_start, i_vld, i_data, output o_we, o_addr, o_wdata, o_busy, o_done);
endinterface

// File: rtl/layer00_out_writer_pix_packer.sv
// layer00_out_writer_pix_packer: lane counter and little-endian 4-pixel word assembly
module layer00_out_writer_pix_packer import layer00_out_writer_pkg::*; (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              push,
  input  logic [PIX_W-1:0]  data,
  output logic [WORD_W-1:0] word,
  output logic              full,
  output logic [LANE_W-1:0] lane
);
  logic [WORD_W-1:0] acc_q;
  // word already contains the pixel being pushed so a completing push can be registered directly
  always_comb begin
    word = acc_q;
    if (push) word[lane*PIX_W +: PIX_W] = data;
  end
  assign full = push && lane == LANE_W'(PACK_N - 1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      lane  <= '0;
    end else if (clr || full) begin
      acc_q <= '0;
      lane  <= '0;
    end else if (push) begin
      acc_q <= word;
      lane  <= lane + 1'b1;
    end
  end
endmodule

// File: rtl/layer00_out_writer.sv
// layer00_out_writer: packs pooled pixels into 32-bit words and writes them to the output BRAM
module layer00_out_writer import layer00_out_writer_pkg::*; #(
  parameter int PIX_PER_FRAME = 16384,
  parameter int ADDR_W        = 12,
  parameter int BASE_ADDR     = 0
) (
  input logic clk,
  input logic rstn,
  layer00_out_writer_if.slave bus
);
  localparam int CNT_W = $clog2(PIX_PER_FRAME + 1);
  state_e            state, nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q, addr_r;
  logic [WORD_W-1:0] wdata_q, pk_word;
  logic [LANE_W-1:0] lane;
  logic              we_q, acc, last, full, flush_we;
  assign acc  = state == RUN && bus.i_vld && !bus.i_start;
  assign last = acc && cnt == CNT_W'(PIX_PER_FRAME - 1);
  layer00_out_writer_pix_packer u_pack (
    .clk  (clk),
    .rstn (rstn),
    .clr  (bus.i_start || state == FLUSH),
    .push (acc),
    .data (bus.i_data),
    .word (pk_word),
    .full (full),
    .lane (lane)
  );
  // the final word always gets a FLUSH cycle so o_done trails the last write by exactly one cycle
  always_comb begin
    nxt = bus.i_start ? RUN : state == RUN ? (last ? FLUSH : RUN) : state == FLUSH ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      addr_r  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state <= nxt;
      we_q  <= acc && full;
      if (bus.i_start) begin
        cnt    <= '0;
        addr_q <= ADDR_W'(BASE_ADDR);
      end else if (acc) begin
        cnt <= cnt + 1'b1;
        if (full || last) begin
          wdata_q <= pk_word;
          addr_r  <= addr_q;
          addr_q  <= addr_q + 1'b1;
        end
      end
    end
  end
  // a partial word still sits in the packer during FLUSH; an abort in that cycle drops it
  assign flush_we    = state == FLUSH && lane != '0 && !bus.i_start;
  assign bus.o_we    = we_q || flush_we;
  assign bus.o_addr  = addr_r;
  assign bus.o_wdata = wdata_q;
  assign bus.o_busy  = state == RUN || state == FLUSH;
  assign bus.o_done  = state == DONE;
endmodule

// File: tb/tb_layer00_out_writer.sv
// tb_layer00_out_writer: two writer configs driven in parallel, scoreboarded against a frame-level model
module tb_layer00_out_writer;
  typedef struct {
    int          due;
    bit          done;
    bit          part;
    logic [2:0]  addr;
    logic [31:0] data;
  } ev_t;
  logic       clk = 1'b0, rstn = 1'b0, st = 1'b0, v = 1'b0;
  logic [7:0] d = 8'h00;
  int         cyc = 0, total = 0, bad = 0;
  bit         fin = 1'b0;
  ev_t        pend[2][$];
  ev_t        exp_q[2][$];
  bit         armed[2];
  int         cnt[2];
  logic [7:0] pix[2][$];
  logic       we_w[2], done_w[2], busy_w[2];
  logic [2:0] addr_w[2];
  logic [31:0] wdata_w[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : u
    layer00_out_writer_if #(.ADDR_W(3)) bus ();
    assign bus.i_start = st;
    assign bus.i_vld   = v;
    assign bus.i_data  = d;
    layer00_out_writer #(
      .PIX_PER_FRAME (g == 0 ? 22 : 8),
      .ADDR_W        (3),
      .BASE_ADDR     (g == 0 ? 5 : 0)
    ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
    );
    assign we_w[g]    = bus.o_we;
    assign done_w[g]  = bus.o_done;
    assign busy_w[g]  = bus.o_busy;
    assign addr_w[g]  = bus.o_addr;
    assign wdata_w[g] = bus.o_wdata;
  end

  function automatic int ppf(int k);
    return k == 0 ? 22 : 8;
  endfunction

  function automatic int base(int k);
    return k == 0 ? 5 : 0;
  endfunction

  // frame-level reference: word n of a frame holds pixels 4n..4n+3 and lands at base+n mod 8
  task automatic model(int k, int c);
    ev_t keep[$];
    ev_t e;
    if (st) begin
      for (int i = 0; i < pend[k].size(); i++)
        if (!((pend[k][i].part && pend[k][i].due == c) || (pend[k][i].done && pend[k][i].due > c)))
          keep.push_back(pend[k][i]);
      pend[k] = keep;
      armed[k] = 1'b1;
      cnt[k] = 0;
      pix[k].delete();
    end else if (v && armed[k]) begin
      pix[k].push_back(d);
      cnt[k]++;
      if (cnt[k] % 4 == 0 || cnt[k] == ppf(k)) begin
        int b;
        b = (cnt[k] - 1) / 4 * 4;
        e.data = '0;
        for (int i = b; i < cnt[k]; i++) e.data |= 32'(pix[k][i]) << (8 * (i - b));
        e.due  = c + 1;
        e.done = 1'b0;
        e.part = cnt[k] % 4 != 0;
        e.addr = 3'((base(k) + (cnt[k] - 1) / 4) % 8);
        pend[k].push_back(e);
      end
      if (cnt[k] == ppf(k)) begin
        e.due  = c + 2;
        e.done = 1'b1;
        e.part = 1'b0;
        e.addr = '0;
        e.data = '0;
        pend[k].push_back(e);
        armed[k] = 1'b0;
      end
    end
    while (pend[k].size() > 0 && pend[k][0].due == c) exp_q[k].push_back(pend[k].pop_front());
  endtask

  task automatic step(bit s, bit vv, logic [7:0] dd);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    st = s;
    v = vv;
    d = dd;
    for (int k = 0; k < 2; k++) model(k, cyc);
  endtask

  task automatic rst_cycle();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    st = 1'b0;
    v = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pend[k].delete();
      armed[k] = 1'b0;
      cnt[k] = 0;
      pix[k].delete();
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (fin) begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (exp_q[k].size() != 0 || pend[k].size() != 0) begin
          bad++;
          $display("FAIL drain[%0d]: %0d events never seen, required 0", k, exp_q[k].size() + pend[k].size());
        end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!rstn) begin
          total++;
          if ({we_w[k], done_w[k], busy_w[k], addr_w[k], wdata_w[k]} != '0) begin
            bad++;
            $display("FAIL reset[%0d] cyc=%0d: we=%0b done=%0b busy=%0b addr=%0d data=%h, required all 0",
                     k, cyc, we_w[k], done_w[k], busy_w[k], addr_w[k], wdata_w[k]);
          end
        end else if (we_w[k] || done_w[k]) begin
          total++;
          if (exp_q[k].size() == 0) begin
            bad++;
            $display("FAIL unexpected[%0d] cyc=%0d: we=%0b done=%0b addr=%0d data=%h, required no event",
                     k, cyc, we_w[k], done_w[k], addr_w[k], wdata_w[k]);
          end else begin
            e = exp_q[k].pop_front();
            if (e.due != cyc || e.done != done_w[k] || we_w[k] == done_w[k] || (e.done && busy_w[k]) ||
                (!e.done && (addr_w[k] != e.addr || wdata_w[k] != e.data))) begin
              bad++;
              $display("FAIL event[%0d] cyc=%0d: we=%0b done=%0b busy=%0b addr=%0d data=%h, required cyc=%0d done=%0b addr=%0d data=%h",
                       k, cyc, we_w[k], done_w[k], busy_w[k], addr_w[k], wdata_w[k], e.due, e.done, e.addr, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (3) rst_cycle();
    step(1, 0, 0);
    for (int i = 0; i < 22; i++) step(0, 1, 8'(i + 1));
    repeat (4) step(0, 0, 0);
    // abort after three pixels; the restart cycle's valid must be dropped
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'hE0 + i));
    step(1, 1, 8'hEE);
    for (int i = 0; i < 22; i++) step(0, 1, 8'(8'hA0 + i));
    repeat (4) step(0, 0, 0);
    // restart landing on the final-write cycle, then on the done cycle
    step(1, 0, 0);
    for (int i = 0; i < 22; i++) step(0, 1, 8'($urandom));
    step(1, 1, 8'h55);
    for (int i = 0; i < 8; i++) step(0, 1, 8'($urandom));
    step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'($urandom));
    repeat (4) step(0, 0, 0);
    // gapped valids, then valids after completion
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'($urandom));
      step(0, 0, 0);
      step(0, 0, 0);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom));
    repeat (4) step(0, 0, 0);
    // reset mid-frame, pixels ignored until the next start
    step(1, 0, 0);
    step(0, 1, 8'h11);
    step(0, 1, 8'h22);
    rst_cycle();
    for (int i = 0; i < 6; i++) step(0, 1, 8'($urandom));
    step(1, 0, 0);
    for (int i = 0; i < 22; i++) step(0, 1, 8'($urandom));
    repeat (4) step(0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 699) == 0) rst_cycle();
      else step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
    end
    repeat (6) step(0, 0, 0);
    fin = 1'b1;
  end
endmodule
